main_control_fsm: RTL

- Multicycle MIPS main control unit. It is the producer side of the aluop interface that the ALU control decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and muxes, plus aluop[1:0] (00 = add, 01 = sub, 10 = use funct field).
- Sits between the instruction register opcode field, the memory ready handshake and the datapath.

---
 rtl/main_control_fsm.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit.
// Walks each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath enables and mux selects. The outputs
// are a Moore decode of the current state; mem_ready only gates the few
// strobes that must not fire while a memory access is still pending.
module main_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic [1:0] aluop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_e;

  // ALU operation and operand select encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  // State and sticky illegal flag; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_RTYPE_EX;
          OP_BEQ:   state_d = S_BEQ;
          OP_ADDI:  state_d = S_ADDI_EX;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_ILLEGAL;
        endcase
      end
      // Only loads and stores reach here, so anything not a store is a load
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_RTYPE_WB: state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      // Encodings 12-14 are unreachable; recover to fetch if ever seen
      default:    state_d = S_FETCH;
    endcase
  end

  // Flag rises on the same edge that enters ILLEGAL so it is visible there
  always_comb begin
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  // Moore output decode; every field not named for a state stays 0
  always_comb begin
    aluop         = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed every cycle, but IR/PC only load once memory answers
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute branch target while the register file is read
        alu_src_b = SRCB_IMM4;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        aluop         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: ; // ILLEGAL and unused encodings drive nothing
    endcase
  end

  // Status outputs
  always_comb begin
    illegal = illegal_q;
    state   = state_q;
  end

endmodule
